// File: rtl/data_mem_responder_if.sv
// Load/store bus between the processor (master) and a memory responder (slave).
interface data_mem_responder_if;
  logic        mem_read_ctrl;
  logic        mem_write_ctrl;
  logic [31:0] mem_address;
  logic [31:0] mem_data_write;
  logic [31:0] mem_data_read;
  logic        mem_ready;
  logic        mem_error;

  modport master (
    output mem_read_ctrl, mem_write_ctrl, mem_address, mem_data_write,
    input  mem_data_read, mem_ready, mem_error
  );

  modport slave (
    input  mem_read_ctrl, mem_write_ctrl, mem_address, mem_data_write,
    output mem_data_read, mem_ready, mem_error
  );
endinterface

// File: rtl/data_mem_responder.sv
// Word-organised memory responder with WAIT_STATES latency and a one-cycle ready pulse.
// Optional MEM_ALIGN_CHECK_EN: rejects accesses whose byte address is not word aligned.
module data_mem_responder #(
  parameter int DEPTH       = 256,
  parameter int WAIT_STATES = 2
) (
  input  logic                 clk,
  input  logic                 rst,
  data_mem_responder_if.slave  bus
);
  localparam int         AW = $clog2(DEPTH);
  localparam logic [3:0] WS = 4'(WAIT_STATES);

  typedef enum logic [1:0] {
    S_IDLE = 2'd0,
    S_WAIT = 2'd1,
    S_DONE = 2'd2
  } state_t;

  state_t          state_reg, state_next;
  logic [3:0]      cnt_reg;
  logic            op_rd_reg, op_wr_reg, err_reg;
  logic [AW-1:0]   idx_reg;
  logic [31:0]     wdata_reg, rdata_reg;
  logic [31:0]     mem [DEPTH];

  logic            req, accept, req_err, align_err, complete;
  logic            eff_rd, eff_wr, eff_err, mem_we, rd_en;
  logic [AW-1:0]   eff_idx;
  logic [31:0]     eff_wdata;

  assign req    = bus.mem_read_ctrl | bus.mem_write_ctrl;
  assign accept = rst & (state_reg == S_IDLE) & req;

`ifdef MEM_ALIGN_CHECK_EN
  assign align_err = |bus.mem_address[1:0];
`else
  assign align_err = 1'b0 & (|bus.mem_address[1:0]);
`endif

  assign req_err = (bus.mem_read_ctrl & bus.mem_write_ctrl)
                 | (|bus.mem_address[31:AW+2])
                 | align_err;

  always_ff @(posedge clk or negedge rst) begin
    if (!rst) state_reg <= S_IDLE;
    else      state_reg <= state_next;
  end

  always_comb begin
    state_next = state_reg;
    unique case (state_reg)
      S_IDLE:  if (req) state_next = (WS == 4'd0) ? S_DONE : S_WAIT;
      S_WAIT:  if (cnt_reg == 4'd1) state_next = S_DONE;
      S_DONE:  state_next = S_IDLE;
      default: state_next = S_IDLE;
    endcase
  end

  // With zero wait states the operation completes on the acceptance edge, so
  // the live bus inputs stand in for the not-yet-latched request.
  always_comb begin
    eff_rd    = op_rd_reg;
    eff_wr    = op_wr_reg;
    eff_err   = err_reg;
    eff_idx   = idx_reg;
    eff_wdata = wdata_reg;
    if (state_reg == S_IDLE) begin
      eff_rd    = bus.mem_read_ctrl;
      eff_wr    = bus.mem_write_ctrl;
      eff_err   = req_err;
      eff_idx   = bus.mem_address[AW+1:2];
      eff_wdata = bus.mem_data_write;
    end
    complete = (accept & (WS == 4'd0)) | ((state_reg == S_WAIT) & (cnt_reg == 4'd1));
    mem_we   = complete & eff_wr & ~eff_err;
    rd_en    = complete & eff_rd;
    bus.mem_ready     = (state_reg == S_DONE);
    bus.mem_error     = (state_reg == S_DONE) & err_reg;
    bus.mem_data_read = rdata_reg;
  end

  always_ff @(posedge clk or negedge rst) begin
    if (!rst) begin
      cnt_reg   <= 4'd0;
      op_rd_reg <= 1'b0;
      op_wr_reg <= 1'b0;
      err_reg   <= 1'b0;
      idx_reg   <= '0;
      wdata_reg <= 32'h0;
      rdata_reg <= 32'h0;
    end else begin
      if (accept) begin
        op_rd_reg <= bus.mem_read_ctrl;
        op_wr_reg <= bus.mem_write_ctrl;
        err_reg   <= req_err;
        idx_reg   <= bus.mem_address[AW+1:2];
        wdata_reg <= bus.mem_data_write;
        cnt_reg   <= WS;
      end else if (state_reg == S_WAIT) begin
        cnt_reg <= cnt_reg - 4'd1;
      end
      if (rd_en) rdata_reg <= eff_err ? 32'h0 : mem[eff_idx];
    end
  end

  // Storage is never reset; writes only happen on a completion edge.
  always_ff @(posedge clk) begin
    if (mem_we) mem[eff_idx] <= eff_wdata;
  end
endmodule

// File: tb/tb_data_mem_responder.sv
// Scoreboard bench: one responder with two wait states and one with none, sharing stimulus.
module tb_data_mem_responder;
  logic        clk = 1'b0;
  logic        rst = 1'b1;
  logic        sel = 1'b0;
  logic        rd = 1'b0;
  logic        wr = 1'b0;
  logic [31:0] addr = 32'h0;
  logic [31:0] wdata = 32'h0;
  int          cyc = 0;
  int          vectors = 0;
  int          miscompares = 0;
  bit          mon_en = 1'b0;
  bit          got_ready;

  always #5 clk = ~clk;
  always @(posedge clk) cyc <= cyc + 1;

  data_mem_responder_if bus2 ();
  data_mem_responder_if bus0 ();

  assign bus2.mem_read_ctrl  = rd & ~sel;
  assign bus2.mem_write_ctrl = wr & ~sel;
  assign bus2.mem_address    = addr;
  assign bus2.mem_data_write = wdata;
  assign bus0.mem_read_ctrl  = rd & sel;
  assign bus0.mem_write_ctrl = wr & sel;
  assign bus0.mem_address    = addr;
  assign bus0.mem_data_write = wdata;

  data_mem_responder #(.DEPTH(256), .WAIT_STATES(2)) dut2 (
    .clk (clk),
    .rst (rst),
    .bus (bus2.slave)
  );

  data_mem_responder #(.DEPTH(256), .WAIT_STATES(0)) dut0 (
    .clk (clk),
    .rst (rst),
    .bus (bus0.slave)
  );

  typedef struct {
    bit          which;
    int          exp_cyc;
    bit          exp_err;
    bit          chk;
    logic [31:0] exp_data;
  } exp_t;

  exp_t q[$];

  task automatic cmp(input string name, input logic [31:0] act, input logic [31:0] exp);
    vectors++;
    if (act !== exp) begin
      miscompares++;
      $display("FAIL %s: got %h, expected %h", name, act, exp);
    end
  endtask

  task automatic on_ready(input bit which, input logic err, input logic [31:0] data);
    exp_t e;
    if (q.size() == 0) begin
      vectors++;
      miscompares++;
      $display("FAIL spurious_ready: dut_ws%0d ready at cycle %0d, expected none", which ? 0 : 2, cyc);
    end else begin
      e = q.pop_front();
      $display("txn dut_ws%0d cycle %0d err=%0b data=%h", which ? 0 : 2, cyc, err, data);
      cmp("responder", 32'(which), 32'(e.which));
      cmp("latency", 32'(cyc), 32'(e.exp_cyc));
      cmp("mem_error", 32'(err), 32'(e.exp_err));
      if (e.chk) cmp("mem_data_read", data, e.exp_data);
    end
  endtask

  always @(negedge clk) begin
    if (mon_en) begin
      if (bus2.mem_ready) on_ready(1'b0, bus2.mem_error, bus2.mem_data_read);
      if (bus0.mem_ready) on_ready(1'b1, bus0.mem_error, bus0.mem_data_read);
    end
  end

  task automatic wait_ready(input bit s);
    got_ready = 1'b0;
    for (int i = 0; i < 40 && !got_ready; i++) begin
      @(negedge clk);
      if (s ? bus0.mem_ready : bus2.mem_ready) got_ready = 1'b1;
    end
    if (!got_ready) begin
      vectors++;
      miscompares++;
      $display("FAIL ready_timeout: no mem_ready within 40 cycles, expected one");
      q.delete();
    end
  endtask

  task automatic push(input bit s, input int exp_cyc, input bit e_err, input bit chk,
                      input logic [31:0] e_data);
    exp_t e;
    e.which    = s;
    e.exp_cyc  = exp_cyc;
    e.exp_err  = e_err;
    e.chk      = chk;
    e.exp_data = e_data;
    q.push_back(e);
  endtask

  task automatic txn(input bit s, input bit r, input bit w, input logic [31:0] a,
                     input logic [31:0] d, input bit e_err, input bit chk,
                     input logic [31:0] e_data);
    @(negedge clk);
    push(s, cyc + 1 + (s ? 0 : 2), e_err, chk, e_data);
    sel   = s;
    rd    = r;
    wr    = w;
    addr  = a;
    wdata = d;
    wait_ready(s);
    rd = 1'b0;
    wr = 1'b0;
    @(negedge clk);
  endtask

  initial begin
    #1 rst = 1'b0;
    @(negedge clk);
    cmp("reset_ready_ws2", 32'(bus2.mem_ready), 32'h0);
    cmp("reset_error_ws2", 32'(bus2.mem_error), 32'h0);
    cmp("reset_rdata_ws2", bus2.mem_data_read, 32'h0);
    cmp("reset_ready_ws0", 32'(bus0.mem_ready), 32'h0);
    cmp("reset_error_ws0", 32'(bus0.mem_error), 32'h0);
    cmp("reset_rdata_ws0", bus0.mem_data_read, 32'h0);
    repeat (2) @(negedge clk);
    rst    = 1'b1;
    mon_en = 1'b1;

    // Two-wait-state responder: writes leave read data untouched.
    txn(0, 0, 1, 32'h10,  32'hDEADBEEF, 0, 1, 32'h0);
    txn(0, 1, 0, 32'h10,  32'h0,        0, 1, 32'hDEADBEEF);
    txn(0, 0, 1, 32'h0,   32'hA5A50001, 0, 1, 32'hDEADBEEF);
    txn(0, 1, 0, 32'h400, 32'h0,        1, 1, 32'h0);
    txn(0, 0, 1, 32'h400, 32'h77777777, 1, 1, 32'h0);
    txn(0, 1, 0, 32'h0,   32'h0,        0, 1, 32'hA5A50001);
    txn(0, 0, 1, 32'h20,  32'h0BADC0DE, 0, 1, 32'hA5A50001);
    txn(0, 1, 1, 32'h20,  32'hFFFFFFFF, 1, 0, 32'h0);
    txn(0, 1, 0, 32'h20,  32'h0,        0, 1, 32'h0BADC0DE);
    txn(0, 0, 1, 32'h40,  32'h11111111, 0, 0, 32'h0);

    // Abort a write in WAIT by reset; it must never complete.
    @(negedge clk);
    sel   = 1'b0;
    wr    = 1'b1;
    addr  = 32'h40;
    wdata = 32'hCAFEF00D;
    @(negedge clk);
    rst = 1'b0;
    wr  = 1'b0;
    #1;
    cmp("abort_ready", 32'(bus2.mem_ready), 32'h0);
    cmp("abort_error", 32'(bus2.mem_error), 32'h0);
    cmp("abort_rdata", bus2.mem_data_read, 32'h0);
    repeat (3) @(negedge clk);
    rst = 1'b1;
    repeat (4) @(negedge clk);
    txn(0, 1, 0, 32'h40, 32'h0, 0, 1, 32'h11111111);

`ifdef MEM_ALIGN_CHECK_EN
    txn(0, 1, 0, 32'h13, 32'h0, 1, 1, 32'h0);
`else
    txn(0, 1, 0, 32'h13, 32'h0, 0, 1, 32'hDEADBEEF);
`endif

    // Zero-wait-state responder.
    txn(1, 0, 1, 32'h8, 32'h12345678, 0, 1, 32'h0);
    @(negedge clk);
    push(1, cyc + 1, 0, 1, 32'h12345678);
    push(1, cyc + 3, 0, 1, 32'h12345678);
    sel  = 1'b1;
    rd   = 1'b1;
    addr = 32'h8;
    wait_ready(1);
    wait_ready(1);
    rd = 1'b0;
    @(negedge clk);
    txn(1, 1, 0, 32'h400, 32'h0, 1, 1, 32'h0);
    txn(1, 0, 1, 32'h4,   32'h55AA55AA, 0, 1, 32'h0);
    txn(1, 1, 0, 32'h4,   32'h0,        0, 1, 32'h55AA55AA);

    repeat (4) @(negedge clk);
    if (q.size() != 0) begin
      vectors++;
      miscompares++;
      $display("FAIL pending_responses: got %0d outstanding, expected 0", q.size());
    end
    $display("== %0d vectors applied, %0d miscompares ==", vectors, miscompares);
    $finish;
  end

  initial begin
    #200000;
    $display("FAIL global_timeout: simulation did not finish, expected completion");
    $fatal(1, "timeout");
  end
endmodule

// File: doc/data_mem_responder.md
Name: data_mem_responder

Overview:
- Memory-side responder for the processor's load/store bus. It answers `mem_read_ctrl`/`mem_write_ctrl` requests that carry `mem_address` and `mem_data_write`.
- Word-organised storage array with a configurable number of wait states. A one-cycle `mem_ready` pulse completes each transfer; `mem_error` flags bad accesses.
- Replaces the zero-latency MEM model so the processor's stall/handshake path can be exercised.

Parameters:
- DEPTH, 256: number of 32-bit words; power of two, 4..65536.
- WAIT_STATES, 2: extra cycles between request acceptance and `mem_ready`; 0..15.

Ports:
- clk  input  1  rising-edge clock
- rst  input  1  reset, asynchronous, active-low (0 = reset)
- mem_read_ctrl  input  1  read request, held high until `mem_ready` is seen
- mem_write_ctrl  input  1  write request, held high until `mem_ready` is seen
- mem_address  input  32  byte address; word index = `mem_address[31:2]`
- mem_data_write  input  32  write data, held stable with the request
- mem_data_read  output  32  read data, registered
- mem_ready  output  1  one-cycle completion pulse
- mem_error  output  1  qualifies `mem_ready`; 1 = access rejected

Behaviour:
- Reset (`rst`=0, asynchronous): state=IDLE, wait counter=0, `mem_ready`=0, `mem_error`=0, `mem_data_read`=32'h0. Array contents are not cleared and are not written while in reset.
- Deasserting reset takes effect at the next clk edge. No request is sampled during reset.
- States:
  - IDLE: samples requests.
  - WAIT: counting down.
  - DONE: `mem_ready` high.
- Acceptance, edge E0: in IDLE with `mem_read_ctrl` | `mem_write_ctrl` = 1, latch op, word index and write data; load counter = WAIT_STATES.
- Routing from IDLE: WAIT_STATES=0 → enter DONE at E0; otherwise → WAIT.
- WAIT: decrement each edge. The edge where the counter is 1 enters DONE.
- Latency: with WAIT_STATES=N, `mem_ready` rises at edge E0+N and stays high exactly one cycle.
- Completion (the edge entering DONE) performs the operation:
  - read: `mem_data_read` <= mem[index].
  - write: mem[index] <= latched data; `mem_data_read` unchanged.
  - Same edge: `mem_ready`<=1, `mem_error`<=error condition.
- DONE → IDLE unconditionally at the next edge; `mem_ready`, `mem_error` <= 0.
  - Requests are not sampled in DONE, so the requester must drop ctrl after seeing `mem_ready`.
  - Back-to-back requests therefore have at least one IDLE cycle between them.
- Input changes after acceptance are ignored; latched values are used.
- `mem_data_read` holds its last read value until the next successful read. On an error read it is driven to 32'h0.
- Error conditions, each giving `mem_ready`=1 and `mem_error`=1 with no array write:
  - `mem_address[31:2]` >= DEPTH (out of range);
  - both `mem_read_ctrl` and `mem_write_ctrl` high at acceptance.
- Reset asserted in WAIT or DONE: abort immediately to IDLE with outputs cleared. A write that had not yet reached its completion edge is not performed.
- Reads and writes to the same word in consecutive transactions behave in program order: a read after a write returns the written data.

Optional Feature:
- Macro: MEM_ALIGN_CHECK_EN.
- Defined: `mem_address[1:0]` != 2'b00 at acceptance is an error. The response is `mem_error`=1 with normal latency and no write; read data = 0.
- Undefined: `mem_address[1:0]` is ignored and the access uses word index `mem_address[31:2]`.

Test Plan:
1. Reset, then WAIT_STATES=2: write 32'hDEADBEEF to address 32'h10, accepted at E0 → `mem_ready`=1, `mem_error`=0 at E0+2 for one cycle. Then read 32'h10 → `mem_data_read`=32'hDEADBEEF with `mem_ready` at E0'+2.
2. WAIT_STATES=0: read of a word previously written with 32'h12345678 → `mem_ready` and data valid at the acceptance edge. A second read with ctrl held high through DONE is accepted only in the following IDLE cycle.
3. DEPTH=256: read address 32'h400 (index 256) → `mem_ready`=1, `mem_error`=1, `mem_data_read`=0. A write to 32'h400 leaves index 0 unchanged (read-back of 32'h0 returns its prior value).
4. Both ctrl lines high at address 32'h20 → error response. mem[8] is unchanged when read afterwards.
5. Write 32'hCAFEF00D to 32'h40; assert `rst`=0 mid-WAIT, then release → no `mem_ready`, outputs 0, and a later read of 32'h40 returns the old value.
6. MEM_ALIGN_CHECK_EN defined: read of 32'h13 → `mem_error`=1. Undefined: the same read returns mem[4] with `mem_error`=0.
